// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with a single-entry
// output register. Grant comes from a fixed select (mode=0) or a rotating
// round-robin pointer (mode=1).
// Optional per-channel saturating transfer counters: define STREAM_MUX_RR_COUNT_EN.
module stream_mux_rr #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           select,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready,
    input  logic [SELW-1:0]           count_sel,
    output logic [15:0]               count_out
);

    localparam logic [SELW:0] CH_LIM = (SELW+1)'(CHANNELS);

    logic            load_en;
    logic            xfer;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic [SELW-1:0] grant;
    logic            grant_ok;
    logic            sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic            rr_hi_found;
    logic            rr_lo_found;
    logic [SELW-1:0] rr_hi;
    logic [SELW-1:0] rr_lo;

    assign load_en = !out_valid || out_ready;

    // Round-robin search: first valid at or above ptr, else first valid below ptr
    always_comb begin
        rr_hi_found = 1'b0;
        rr_lo_found = 1'b0;
        rr_hi       = '0;
        rr_lo       = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (in_valid[j] && (SELW'(j) >= ptr) && !rr_hi_found) begin
                rr_hi_found = 1'b1;
                rr_hi       = SELW'(j);
            end
            if (in_valid[j] && (SELW'(j) < ptr) && !rr_lo_found) begin
                rr_lo_found = 1'b1;
                rr_lo       = SELW'(j);
            end
        end
    end

    // Grant selection; an out-of-range fixed select grants nothing
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        if (mode) begin
            grant_ok = rr_hi_found || rr_lo_found;
            grant    = rr_hi_found ? rr_hi : rr_lo;
        end else begin
            grant_ok = ({1'b0, select} < CH_LIM);
            grant    = select;
        end
    end

    // Granted-channel data/valid mux and ready fan-out
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant_ok && (SELW'(j) == grant)) begin
                sel_valid   = in_valid[j];
                sel_data    = in_data[j*WIDTH +: WIDTH];
                in_ready[j] = load_en && !reset;
            end
        end
    end

    assign xfer     = grant_ok && sel_valid && load_en && !reset;
    assign ptr_next = ({1'b0, grant} == (CH_LIM - (SELW+1)'(1))) ? '0 : grant + SELW'(1);

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_RR_COUNT_EN
    logic [15:0] cnt [CHANNELS];

    // Per-channel saturating transfer counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < CHANNELS; j++) begin
                cnt[j] <= '0;
            end
        end else if (xfer) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if ((SELW'(j) == grant) && (cnt[j] != 16'hFFFF)) begin
                    cnt[j] <= cnt[j] + 16'd1;
                end
            end
        end
    end

    // Counter read port; out-of-range index reads as zero
    always_comb begin
        count_out = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (SELW'(j) == count_sel) begin
                count_out = cnt[j];
            end
        end
    end
`else
    logic unused_count_sel;
    assign unused_count_sel = ^count_sel;
    assign count_out        = 16'h0000;
`endif

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 The block SHALL derive SELW = max(1, ceil(log2(CHANNELS))) and use it as the channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 select  input  SELW  channel index used when mode=0.
REQ-008 in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  per-channel accept; combinational.
REQ-011 out_valid  output  1  output register holds data.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_chan  output  SELW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 count_sel  input  SELW  transfer-counter read index.
REQ-016 count_out  output  16  transfer count of channel count_sel; combinational read.

Function
REQ-017 The block SHALL hold a single-entry output register; load_en = !out_valid || out_ready.
REQ-018 In mode=0 the grant SHALL be select; if select >= CHANNELS, no channel is granted.
REQ-019 In mode=1 the grant SHALL be the first channel with in_valid high, searching from index ptr upward and wrapping modulo CHANNELS; no valid channel means no grant.
REQ-020 in_ready[g] SHALL equal load_en for the granted channel g; every other in_ready bit SHALL be 0.
REQ-021 A transfer SHALL occur when in_valid[g] && in_ready[g]; on that edge out_data <= channel g data, out_chan <= g, out_valid <= 1.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-023 If out_valid && out_ready and no transfer occurs, out_valid SHALL go to 0; out_data and out_chan SHALL hold.
REQ-024 Simultaneous output pop and input transfer SHALL sustain 1 word/cycle with no bubble.
REQ-025 out_valid=1 && out_ready=0 SHALL hold out_data and out_chan stable and drive all in_ready bits to 0.
REQ-026 ptr (SELW bits) SHALL update to (g+1) mod CHANNELS on every transfer in either mode, and SHALL hold otherwise.
REQ-027 A mode or select change SHALL affect only the current cycle's grant; the register contents and ptr are unaffected.
REQ-028 in_valid on non-granted channels SHALL NOT change any state.

Reset
REQ-029 While reset=1: out_valid=0, out_data=0, out_chan=0, ptr=0, all counters=0; in_ready SHALL be all 0 during reset.
REQ-030 Reset SHALL override a concurrent transfer; data presented in the reset cycle is dropped.

Configuration
REQ-031 With STREAM_MUX_RR_COUNT_EN defined, each channel SHALL have a 16-bit counter that increments on every transfer from that channel and saturates at 16'hFFFF; count_out = counter[count_sel], or 0 if count_sel >= CHANNELS.
REQ-032 Without STREAM_MUX_RR_COUNT_EN, no counters SHALL exist; the count_sel port SHALL remain and count_out SHALL be constant 0.

Verification
REQ-033 mode=0, select=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2.
REQ-034 mode=1, all valid, out_ready=1 for 8 cycles after reset -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
REQ-035 mode=1, only ch3 and ch1 valid, ptr=2 -> grant 3, then grant 1, then grant 3.
REQ-036 out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data stable; release out_ready -> pop and reload in the same cycle.
REQ-037 mode=0, CHANNELS=3, select=3 -> in_ready=0, no transfer, out_valid stays 0.
REQ-038 With STREAM_MUX_RR_COUNT_EN: 70000 ch0 transfers -> count_out(count_sel=0)=16'hFFFF; reset mid-stream -> all counters 0 and out_valid=0 on the next cycle.
